// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel stream FIFO: in-band codes, FSM states
// and the write-side masking helper.
package pixel_pkg;

  localparam logic [7:0] SYNC_CODE  = 8'h03;
  localparam logic [7:0] BLANK_CODE = 8'h00;
  localparam logic [7:0] PIXEL_MASK = 8'hFC;

  typedef enum logic [1:0] {
    FILL   = 2'b00,
    SYNC   = 2'b01,
    STREAM = 2'b10
  } fifo_state_t;

  // Bits [1:0] are reserved for the sync code, which only this block emits.
  function automatic logic [7:0] mask_pixel(input logic [7:0] d);
    return d & PIXEL_MASK;
  endfunction

endpackage

// File: rtl/pixel_fifo_mem.sv
// Storage array for the pixel stream FIFO: synchronous write, asynchronous
// read of the head entry.
module pixel_fifo_mem #(
  parameter int DEPTH     = 16,
  parameter int ADDR_BITS = 4,
  parameter int WIDTH     = 8
) (
  input  logic                 i_clk,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_waddr,
  input  logic [WIDTH-1:0]     i_wdata,
  input  logic [ADDR_BITS-1:0] i_raddr,
  output logic [WIDTH-1:0]     o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Tail write; contents are never reset, occupancy tracking makes them don't-care.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pixel_stream_fifo.sv
// Elastic byte buffer between the PPU handshake and the VGA driver pixel input.
// Optional build macro: PIXEL_FIFO_STATS_EN adds a saturating underrun counter.
module pixel_stream_fifo
  import pixel_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ADDR_BITS   = 4,
  parameter int PRIME_LEVEL = 8,
  parameter int PIX_DIV     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           in_data,
  input  logic                 in_stb,
  output logic                 in_ack,
  output logic [7:0]           out_data,
  output logic                 out_tick,
  output logic [ADDR_BITS:0]   level,
  output logic                 underrun
`ifdef PIXEL_FIFO_STATS_EN
  ,
  output logic [15:0]          underrun_count
`endif
);

  localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int LVL_W = ADDR_BITS + 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(PIX_DIV - 1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_PRIME = LVL_W'(PRIME_LEVEL);

  logic [DIV_W-1:0]     r_div;
  logic [ADDR_BITS-1:0] r_wptr;
  logic [ADDR_BITS-1:0] r_rptr;
  logic [LVL_W-1:0]     r_level;
  logic                 r_in_ack;
  logic [7:0]           r_out_data;
  logic                 r_out_tick;
  logic                 r_underrun;
  fifo_state_t          r_state;

  logic                 w_tick;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_underrun;
  logic [7:0]           w_head;
  logic [7:0]           w_wdata;
  logic [7:0]           w_out_val;
  fifo_state_t          w_next_state;

  assign w_tick  = (r_div == DIV_LAST);
  assign w_empty = (r_level == {LVL_W{1'b0}});
  assign w_full  = (r_level == LVL_FULL);
  // The pending ack blocks the edge right after acceptance, since the PPU still holds stb.
  assign w_push  = in_stb && !r_in_ack && !w_full;
  assign w_wdata = mask_pixel(in_data);

  pixel_fifo_mem #(
    .DEPTH     (DEPTH),
    .ADDR_BITS (ADDR_BITS),
    .WIDTH     (8)
  ) u_mem (
    .i_clk   (clk),
    .i_we    (w_push),
    .i_waddr (r_wptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rptr),
    .o_rdata (w_head)
  );

  // Pixel tick divider, wrapping at PIX_DIV-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= {DIV_W{1'b0}};
    end else if (w_tick) begin
      r_div <= {DIV_W{1'b0}};
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Input handshake, pointers and explicit occupancy counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_ack <= 1'b0;
      r_wptr   <= {ADDR_BITS{1'b0}};
      r_rptr   <= {ADDR_BITS{1'b0}};
      r_level  <= {LVL_W{1'b0}};
    end else begin
      r_in_ack <= w_push;
      if (w_push) begin
        r_wptr <= r_wptr + ADDR_BITS'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + ADDR_BITS'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FILL;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next state and per-tick output selection.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_underrun   = 1'b0;
    w_out_val    = BLANK_CODE;
    case (r_state)
      FILL: begin
        w_out_val = BLANK_CODE;
        if (r_level >= LVL_PRIME) begin
          w_next_state = SYNC;
        end else begin
          w_next_state = FILL;
        end
      end
      SYNC: begin
        w_out_val = SYNC_CODE;
        if (w_tick) begin
          w_next_state = STREAM;
        end else begin
          w_next_state = SYNC;
        end
      end
      STREAM: begin
        if (!w_tick) begin
          w_next_state = STREAM;
        end else if (w_empty) begin
          w_out_val    = BLANK_CODE;
          w_underrun   = 1'b1;
          w_next_state = FILL;
        end else begin
          w_out_val    = w_head;
          w_pop        = 1'b1;
          w_next_state = STREAM;
        end
      end
      default: begin
        w_next_state = FILL;
      end
    endcase
  end

  // Registered pixel outputs; out_data only moves on a tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data <= BLANK_CODE;
      r_out_tick <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_out_tick <= w_tick;
      r_underrun <= w_underrun;
      if (w_tick) begin
        r_out_data <= w_out_val;
      end
    end
  end

  assign in_ack   = r_in_ack;
  assign out_data = r_out_data;
  assign out_tick = r_out_tick;
  assign level    = r_level;
  assign underrun = r_underrun;

`ifdef PIXEL_FIFO_STATS_EN
  logic [15:0] r_underrun_count;

  // Saturating underrun counter, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_underrun_count <= 16'h0000;
    end else if (w_underrun && (r_underrun_count != 16'hFFFF)) begin
      r_underrun_count <= r_underrun_count + 16'h0001;
    end
  end

  assign underrun_count = r_underrun_count;
`endif

endmodule

// File: tb/tb_pixel_stream_fifo.sv
// Self-checking bench for pixel_stream_fifo: a default instance (a) and a
// slow-tick instance (b, PIX_DIV=64) for backpressure.
module tb_pixel_stream_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data_a, in_data_b;
  logic       in_stb_a, in_stb_b;
  logic       in_ack_a, in_ack_b;
  logic [7:0] out_data_a, out_data_b;
  logic       out_tick_a, out_tick_b;
  logic [4:0] level_a, level_b;
  logic       underrun_a, underrun_b;
`ifdef PIXEL_FIFO_STATS_EN
  logic [15:0] underrun_count_a, underrun_count_b;
`endif

  always #5 clk = ~clk;

  pixel_stream_fifo u_dut_a (
    .clk(clk), .rst(rst), .in_data(in_data_a), .in_stb(in_stb_a), .in_ack(in_ack_a),
    .out_data(out_data_a), .out_tick(out_tick_a), .level(level_a), .underrun(underrun_a)
`ifdef PIXEL_FIFO_STATS_EN
    , .underrun_count(underrun_count_a)
`endif
  );

  pixel_stream_fifo #(.PIX_DIV(64)) u_dut_b (
    .clk(clk), .rst(rst), .in_data(in_data_b), .in_stb(in_stb_b), .in_ack(in_ack_b),
    .out_data(out_data_b), .out_tick(out_tick_b), .level(level_b), .underrun(underrun_b)
`ifdef PIXEL_FIFO_STATS_EN
    , .underrun_count(underrun_count_b)
`endif
  );

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0] obs_a[$], obs_b[$];
  logic [7:0] exp_a[$], exp_b[$];
  int         und_a[$], und_b[$];
  logic       ppu_en_a = 1'b0, ppu_en_b = 1'b0;
  logic [7:0] ppu_val_a = 8'h00, ppu_val_b = 8'h00;

  typedef struct {
    logic       rst;
    logic       stb;
    logic [7:0] data;
    logic       ack;
    logic [4:0] lvl;
    logic       tick;
    logic [7:0] out;
    logic       und;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Tick/underrun monitors on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_tick_a) obs_a.push_back(out_data_a);
      if (underrun_a) und_a.push_back(obs_a.size() - 1);
      if (out_tick_b) obs_b.push_back(out_data_b);
      if (underrun_b) und_b.push_back(obs_b.size() - 1);
    end
  end

  // PPU model a: holds stb until acked, logs every accepted (masked) byte.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (in_ack_a) begin
        exp_a.push_back(in_data_a & 8'hFC);
        ppu_val_a = ppu_val_a + 8'd1;
      end
      if (ppu_en_a) begin
        in_stb_a  = 1'b1;
        in_data_a = ppu_val_a;
      end
    end
  end

  // PPU model b.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (in_ack_b) begin
        exp_b.push_back(in_data_b & 8'hFC);
        ppu_val_b = ppu_val_b + 8'd1;
      end
      if (ppu_en_b) begin
        in_stb_b  = 1'b1;
        in_data_b = ppu_val_b;
      end
    end
  end

  task automatic do_reset(input logic [7:0] va, input logic [7:0] vb);
    rst = 1'b1;
    ppu_en_a = 1'b0; ppu_en_b = 1'b0;
    in_stb_a = 1'b0; in_stb_b = 1'b0;
    @(posedge clk); #1;
    obs_a.delete(); obs_b.delete(); und_a.delete(); und_b.delete();
    exp_a.delete(); exp_b.delete();
    ppu_val_a = va; ppu_val_b = vb;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_ticks_a(input int n, input int budget);
    int c = 0;
    while (obs_a.size() < n && c < budget) begin
      @(posedge clk); #1; c++;
    end
    check("wait_ticks_a", 32'(obs_a.size() >= n), 32'd1);
  endtask

  task automatic wait_ticks_b(input int n, input int budget);
    int c = 0;
    while (obs_b.size() < n && c < budget) begin
      @(posedge clk); #1; c++;
    end
    check("wait_ticks_b", 32'(obs_b.size() >= n), 32'd1);
  endtask

  task automatic wait_und_a(input int n, input int budget);
    int c = 0;
    while (und_a.size() < n && c < budget) begin
      @(posedge clk); #1; c++;
    end
    check("wait_underrun_a", 32'(und_a.size() >= n), 32'd1);
  endtask

  task automatic stop_ppu_a();
    @(negedge clk);
    ppu_en_a = 1'b0;
    in_stb_a = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int s, s2, u, n1, cnt, acks;
    logic [7:0] e;

    //            rst   stb   data   ack   lvl    tick  out    und
    tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 8'hAB, 1'b1, 5'd1, 1'b0, 8'h00, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 8'hAB, 1'b0, 5'd1, 1'b0, 8'h00, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 8'hCD, 1'b1, 5'd2, 1'b0, 8'h00, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 8'hCD, 1'b0, 5'd2, 1'b1, 8'h00, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 8'hCD, 1'b0, 5'd2, 1'b0, 8'h00, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 8'h11, 1'b1, 5'd3, 1'b0, 8'h00, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 8'h11, 1'b0, 5'd0, 1'b0, 8'h00, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 8'h11, 1'b1, 5'd1, 1'b0, 8'h00, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 8'h11, 1'b0, 5'd1, 1'b0, 8'h00, 1'b0};

    rst = 1'b1;
    in_stb_a = 1'b0; in_data_a = 8'h00;
    in_stb_b = 1'b0; in_data_b = 8'h00;
    @(posedge clk); #1;

    // Handshake, level, reset and tick timing vectors.
    for (int i = 0; i < 10; i++) begin
      rst = tbl[i].rst;
      in_stb_a = tbl[i].stb;
      in_data_a = tbl[i].data;
      @(posedge clk); #1;
      check($sformatf("vec%0d_ack", i), 32'(in_ack_a), 32'(tbl[i].ack));
      check($sformatf("vec%0d_level", i), 32'(level_a), 32'(tbl[i].lvl));
      check($sformatf("vec%0d_tick", i), 32'(out_tick_a), 32'(tbl[i].tick));
      check($sformatf("vec%0d_out", i), 32'(out_data_a), 32'(tbl[i].out));
      check($sformatf("vec%0d_underrun", i), 32'(underrun_a), 32'(tbl[i].und));
    end

    // Reset then idle: only blank ticks.
    do_reset(8'h00, 8'h00);
    repeat (60) @(posedge clk);
    #1;
    check("idle_tick_count", 32'(obs_a.size() >= 14), 32'd1);
    cnt = 0;
    foreach (obs_a[i]) if (obs_a[i] != 8'h00) cnt++;
    check("idle_nonblank", 32'(cnt), 32'd0);
    check("idle_level", 32'(level_a), 32'd0);
    check("idle_underruns", 32'(und_a.size()), 32'd0);

    // Prime and sync: blanks, one sync code, then masked F0, F0, F0, F0, F4...
    do_reset(8'hF0, 8'h00);
    ppu_en_a = 1'b1;
    wait_ticks_a(30, 400);
    s = -1;
    foreach (obs_a[i]) if (s < 0 && obs_a[i] != 8'h00) s = i;
    check("prime_sync_found", 32'(s >= 1), 32'd1);
    if (s < 0) s = 0;
    check("prime_sync_code", 32'(obs_a[s]), 32'h03);
    cnt = 0;
    foreach (obs_a[i]) if (obs_a[i] == 8'h03) cnt++;
    check("prime_one_sync", 32'(cnt), 32'd1);
    for (int i = 0; i < 12 && (s + 1 + i) < obs_a.size(); i++) begin
      e = 8'hF0 + 8'(i);
      e = e & 8'hFC;
      check($sformatf("prime_data%0d", i), 32'(obs_a[s + 1 + i]), 32'(e));
    end
    check("prime_underruns", 32'(und_a.size()), 32'd0);

    // Full backpressure on the slow instance.
    do_reset(8'h00, 8'h20);
    ppu_en_b = 1'b1;
    cnt = 0;
    while (level_b != 5'd16 && cnt < 200) begin
      @(posedge clk); #1; cnt++;
    end
    check("bp_level_full", 32'(level_b), 32'd16);
    acks = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (in_ack_b) acks++;
    end
    check("bp_ack_stalled", 32'(acks), 32'd0);
    check("bp_level_held", 32'(level_b), 32'd16);
    check("bp_accepted", 32'(exp_b.size()), 32'd16);
    wait_ticks_b(14, 1200);
    s = -1;
    foreach (obs_b[i]) if (s < 0 && obs_b[i] != 8'h00) s = i;
    check("bp_sync_found", 32'(s >= 0), 32'd1);
    if (s < 0) s = 0;
    check("bp_sync_code", 32'(obs_b[s]), 32'h03);
    for (int i = 0; (s + 1 + i) < obs_b.size(); i++) begin
      e = 8'h20 + 8'(i);
      e = e & 8'hFC;
      check($sformatf("bp_data%0d", i), 32'(obs_b[s + 1 + i]), 32'(e));
    end
    check("bp_underruns", 32'(und_b.size()), 32'd0);

    // Underrun recovery: drain, blank+underrun, refill, exactly one sync, resume.
    do_reset(8'h40, 8'h00);
    ppu_en_a = 1'b1;
    wait_ticks_a(12, 300);
    stop_ppu_a();
    wait_und_a(1, 400);
    n1 = exp_a.size();
    u = (und_a.size() > 0) ? und_a[0] : 0;
    ppu_en_a = 1'b1;
    wait_ticks_a(u + 20, 400);
    s = -1;
    foreach (obs_a[i]) if (s < 0 && obs_a[i] != 8'h00) s = i;
    if (s < 0) s = 0;
    check("ur_first_sync", 32'(obs_a[s]), 32'h03);
    check("ur_drained_count", 32'(u - s - 1), 32'(n1));
    for (int i = 0; i < n1 && (s + 1 + i) < obs_a.size(); i++) begin
      check($sformatf("ur_data%0d", i), 32'(obs_a[s + 1 + i]), 32'(exp_a[i]));
    end
    check("ur_blank_at_underrun", 32'(obs_a[u]), 32'h00);
    s2 = -1;
    for (int i = u + 1; i < obs_a.size(); i++) if (s2 < 0 && obs_a[i] != 8'h00) s2 = i;
    check("ur_resync_found", 32'(s2 > u), 32'd1);
    if (s2 < 0) s2 = u;
    check("ur_resync_code", 32'(obs_a[s2]), 32'h03);
    for (int i = 0; (s2 + 1 + i) < obs_a.size() && (n1 + i) < exp_a.size(); i++) begin
      check($sformatf("ur_resume%0d", i), 32'(obs_a[s2 + 1 + i]), 32'(exp_a[n1 + i]));
    end
    check("ur_underrun_count", 32'(und_a.size()), 32'd1);

`ifdef PIXEL_FIFO_STATS_EN
    for (int k = 2; k <= 3; k++) begin
      ppu_en_a = 1'b1;
      wait_ticks_a(obs_a.size() + 12, 300);
      stop_ppu_a();
      wait_und_a(k, 400);
    end
    @(posedge clk); #1;
    check("stats_count_a", 32'(underrun_count_a), 32'd3);
    check("stats_count_b", 32'(underrun_count_b), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
